// File: rtl/parity_rx_if.sv
// parity_rx_if: serial input and valid/ready word output of the parity receiver
interface parity_rx_if #(parameter int DATA_W = 4);
   logic              sin_valid;
   logic              sin;
   logic              sof;
   logic [DATA_W-1:0] data_out;
   logic              par_err;
   logic              out_valid;
   logic              out_ready;
   logic              overrun;
   modport master (output sin_valid, sin, sof, out_ready, input data_out, par_err, out_valid, overrun);
   modport slave (input sin_valid, sin, sof, out_ready, output data_out, par_err, out_valid, overrun);
endinterface

// File: rtl/parity_rx.sv
// parity_rx: LSB-first serial deserialiser with parity check and a one-word output register
module parity_rx #(
   parameter int DATA_W = 4,
   parameter int ODD = 0
) (
   input logic clk,
   input logic rst,
   parity_rx_if.slave bus
);
   localparam int CW = $clog2(DATA_W) + 1;
   typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [DATA_W-1:0] shift, shift_n;
   logic              done, err, free;
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      shift_n = shift;
      done = 1'b0;
      if (bus.sin_valid) begin
         if (bus.sof) begin
            shift_n = DATA_W'(bus.sin);
            cnt_n = CW'(1);
            state_n = (DATA_W == 1) ? PARITY : DATA;
         end else if (state == DATA) begin
            shift_n = shift | (DATA_W'(bus.sin) << cnt);
            cnt_n = cnt + CW'(1);
            state_n = (cnt == CW'(DATA_W - 1)) ? PARITY : DATA;
         end else if (state == PARITY) begin
            done = 1'b1;
            cnt_n = '0;
            state_n = IDLE;
         end
      end
   end
   assign err = (^shift) ^ bus.sin ^ (ODD != 0);
   // a word leaving this cycle frees the register for the frame completing now
   assign free = !bus.out_valid || bus.out_ready;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         shift <= '0;
         bus.data_out <= '0;
         bus.par_err <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.overrun <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         shift <= shift_n;
         if (done && free) begin
            bus.data_out <= shift;
            bus.par_err <= err;
            bus.out_valid <= 1'b1;
         end else if (bus.out_ready) bus.out_valid <= 1'b0;
         if (done && !free) bus.overrun <= 1'b1;
      end
   end
endmodule

// File: tb/tb_parity_rx.sv
// tb_parity_rx: directed checks of the even-parity receiver with an odd-parity twin
module tb_parity_rx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sv = 1'b0, s = 1'b0, sf = 1'b0, rdy = 1'b0;
   int checks = 0, errors = 0;
   parity_rx_if #(.DATA_W(4)) b0 ();
   parity_rx_if #(.DATA_W(4)) b1 ();
   assign b0.sin_valid = sv;
   assign b0.sin = s;
   assign b0.sof = sf;
   assign b0.out_ready = rdy;
   assign b1.sin_valid = sv;
   assign b1.sin = s;
   assign b1.sof = sf;
   assign b1.out_ready = rdy;
   parity_rx #(.DATA_W(4), .ODD(0)) dut_even (.clk(clk), .rst(rst), .bus(b0));
   parity_rx #(.DATA_W(4), .ODD(1)) dut_odd (.clk(clk), .rst(rst), .bus(b1));
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic f, input logic b);
      sv = 1'b1;
      sf = f;
      s = b;
      tick();
   endtask

   task automatic idle_bus();
      sv = 1'b0;
      sf = 1'b0;
      s = 1'b0;
   endtask

   task automatic frame(input logic [3:0] d, input logic p);
      for (int i = 0; i < 4; i++) send(i == 0, d[i]);
      send(1'b0, p);
      idle_bus();
   endtask

   task automatic accept();
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
   endtask

   task automatic do_reset();
      idle_bus();
      rdy = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks += 4;
      if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", b0.out_valid); end
      if (b0.data_out !== 4'h0) begin errors++; $display("FAIL reset_data got %h want 0", b0.data_out); end
      if (b0.par_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", b0.par_err); end
      if (b0.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", b0.overrun); end
   endtask

   task automatic test_basic();
      frame(4'b0001, 1'b1);
      checks += 3;
      if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", b0.out_valid); end
      if (b0.data_out !== 4'b0001) begin errors++; $display("FAIL basic_data got %h want 1", b0.data_out); end
      if (b0.par_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", b0.par_err); end
      accept();
      checks++;
      if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL basic_accept got %b want 0", b0.out_valid); end
   endtask

   task automatic test_patterns();
      frame(4'hF, 1'b0);
      checks += 2;
      if (b0.data_out !== 4'hF) begin errors++; $display("FAIL pat_f_data got %h want f", b0.data_out); end
      if (b0.par_err !== 1'b0) begin errors++; $display("FAIL pat_f_err got %b want 0", b0.par_err); end
      accept();
      frame(4'b0100, 1'b0);
      checks += 3;
      if (b0.data_out !== 4'h4) begin errors++; $display("FAIL pat_4_data got %h want 4", b0.data_out); end
      if (b0.par_err !== 1'b1) begin errors++; $display("FAIL pat_4_err got %b want 1", b0.par_err); end
      if (b1.par_err !== 1'b0) begin errors++; $display("FAIL pat_4_odd_err got %b want 0", b1.par_err); end
      accept();
   endtask

   task automatic test_stall_restart();
      send(1'b1, 1'b1);
      send(1'b0, 1'b0);
      idle_bus();
      tick();
      tick();
      checks++;
      if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL stall_valid got %b want 0", b0.out_valid); end
      frame(4'b0010, 1'b1);
      checks += 3;
      if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL restart_valid got %b want 1", b0.out_valid); end
      if (b0.data_out !== 4'h2) begin errors++; $display("FAIL restart_data got %h want 2", b0.data_out); end
      if (b0.par_err !== 1'b0) begin errors++; $display("FAIL restart_err got %b want 0", b0.par_err); end
      accept();
      tick();
      checks += 2;
      if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL restart_single got %b want 0", b0.out_valid); end
      if (b0.overrun !== 1'b0) begin errors++; $display("FAIL restart_overrun got %b want 0", b0.overrun); end
   endtask

   task automatic test_overrun();
      frame(4'h1, 1'b1);
      frame(4'h3, 1'b0);
      checks += 3;
      if (b0.data_out !== 4'h1) begin errors++; $display("FAIL ovr_data got %h want 1", b0.data_out); end
      if (b0.overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", b0.overrun); end
      if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", b0.out_valid); end
      accept();
      tick();
      checks += 2;
      if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept got %b want 0", b0.out_valid); end
      if (b0.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", b0.overrun); end
      do_reset();
      checks++;
      if (b0.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", b0.overrun); end
   endtask

   task automatic test_back_to_back();
      frame(4'h1, 1'b1);
      for (int i = 0; i < 4; i++) send(i == 0, i < 2);
      rdy = 1'b1;
      send(1'b0, 1'b0);
      rdy = 1'b0;
      idle_bus();
      checks += 4;
      if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", b0.out_valid); end
      if (b0.data_out !== 4'h3) begin errors++; $display("FAIL b2b_data got %h want 3", b0.data_out); end
      if (b0.par_err !== 1'b0) begin errors++; $display("FAIL b2b_err got %b want 0", b0.par_err); end
      if (b0.overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", b0.overrun); end
      accept();
   endtask

   task automatic test_reset_midframe();
      send(1'b1, 1'b1);
      send(1'b0, 1'b1);
      rst = 1'b1;
      send(1'b0, 1'b1);
      rst = 1'b0;
      idle_bus();
      tick();
      checks++;
      if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", b0.out_valid); end
      frame(4'b1000, 1'b1);
      checks += 5;
      if (b0.data_out !== 4'h8) begin errors++; $display("FAIL mid_data got %h want 8", b0.data_out); end
      if (b0.par_err !== 1'b0) begin errors++; $display("FAIL mid_err got %b want 0", b0.par_err); end
      if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL mid_odd_valid got %b want 1", b1.out_valid); end
      if (b1.data_out !== 4'h8) begin errors++; $display("FAIL mid_odd_data got %h want 8", b1.data_out); end
      if (b1.par_err !== 1'b1) begin errors++; $display("FAIL mid_odd_err got %b want 1", b1.par_err); end
      accept();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_patterns();
      test_stall_restart();
      test_overrun();
      test_back_to_back();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
